// File: rtl/c2h_stream_pkt_gen.sv
// Deterministic AXI-Stream packet generator feeding the SDE C2H stream input.
// Each beat carries a running dword D (optionally rotated per lane) so the host can predict every byte.
module c2h_stream_pkt_gen #(
    parameter int DATA_WIDTH = 512,
    parameter int USER_WIDTH = 64,
    parameter int LEN_WIDTH  = 16,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cfg_start,
    input  logic                    cfg_stop,
    input  logic                    cfg_no_scramble,
    input  logic                    cfg_num_pkts_en,
    input  logic [31:0]             cfg_seed,
    input  logic [LEN_WIDTH-1:0]    cfg_pkt_len,
    input  logic [CNT_WIDTH-1:0]    cfg_num_pkts,
    output logic [DATA_WIDTH-1:0]   m_axis_tdata,
    output logic [DATA_WIDTH/8-1:0] m_axis_tkeep,
    output logic                    m_axis_tlast,
    output logic [USER_WIDTH-1:0]   m_axis_tuser,
    output logic                    m_axis_tvalid,
    input  logic                    m_axis_tready,
    output logic                    stat_busy,
    output logic                    stat_done,
    output logic [CNT_WIDTH-1:0]    stat_pkt_cnt
);

    localparam int NDW = DATA_WIDTH / 32;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SEND  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]           r_state;
    logic [31:0]          r_d;
    logic [LEN_WIDTH-1:0] r_beat;
    logic [LEN_WIDTH-1:0] r_len_m1;
    logic [CNT_WIDTH-1:0] r_pkt;
    logic [CNT_WIDTH-1:0] r_num_pkts;
    logic [CNT_WIDTH-1:0] r_pkt_cnt;
    logic                 r_no_scr;
    logic                 r_num_en;
    logic                 r_done;

    logic w_valid;
    logic w_last;
    logic w_xfer;
    logic w_last_xfer;
    logic w_cnt_end;

    // tvalid comes straight from the state so an asynchronous reset removes it at once.
    assign w_valid     = (r_state != S_IDLE);
    assign w_last      = (r_beat == r_len_m1);
    assign w_xfer      = w_valid && m_axis_tready;
    assign w_last_xfer = w_xfer && w_last;
    assign w_cnt_end   = r_num_en && (r_pkt == r_num_pkts);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_d        <= '0;
            r_beat     <= '0;
            r_len_m1   <= '0;
            r_pkt      <= '0;
            r_num_pkts <= '0;
            r_pkt_cnt  <= '0;
            r_no_scr   <= 1'b0;
            r_num_en   <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (cfg_start) begin
                        r_d        <= cfg_seed;
                        r_len_m1   <= (cfg_pkt_len == '0) ? '0 : cfg_pkt_len - 1'b1;
                        r_num_pkts <= cfg_num_pkts;
                        r_no_scr   <= cfg_no_scramble;
                        r_num_en   <= cfg_num_pkts_en;
                        r_beat     <= '0;
                        r_pkt      <= '0;
                        r_pkt_cnt  <= '0;
                        r_state    <= S_SEND;
                    end
                end
                S_SEND, S_DRAIN: begin
                    if (w_xfer) begin
                        r_d    <= r_d + 32'd1;
                        r_beat <= w_last ? '0 : r_beat + 1'b1;
                    end
                    if (w_last_xfer) begin
                        r_pkt <= r_pkt + 1'b1;
                        if (r_pkt_cnt != '1) begin
                            r_pkt_cnt <= r_pkt_cnt + 1'b1;
                        end
                    end
                    // Counted end, drain completion and a stop on the tlast beat all share one done pulse.
                    if (w_last_xfer && (r_state == S_DRAIN || cfg_stop || w_cnt_end)) begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b1;
                    end else if (r_state == S_SEND && cfg_stop) begin
                        r_state <= S_DRAIN;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    for (genvar j = 0; j < NDW; j++) begin : g_dword
        logic [63:0] w_dbl;
        assign w_dbl = {r_d, r_d} << (j % 32);
        assign m_axis_tdata[32*j +: 32] = r_no_scr ? r_d : w_dbl[63:32];
    end

    assign m_axis_tkeep  = '1;
    assign m_axis_tvalid = w_valid;
    assign m_axis_tlast  = w_valid && w_last;
    assign m_axis_tuser  = USER_WIDTH'(r_pkt);
    assign stat_busy     = w_valid;
    assign stat_done     = r_done;
    assign stat_pkt_cnt  = r_pkt_cnt;

endmodule

// File: tb/tb_c2h_stream_pkt_gen.sv
// Directed self-checking bench for c2h_stream_pkt_gen.
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_c2h_stream_pkt_gen;

    localparam int DW = 512;
    localparam int KW = DW / 8;
    localparam int UW = 64;
    localparam int LW = 16;
    localparam int CW = 32;

    logic          clk;
    logic          rst_n;
    logic          cfg_start;
    logic          cfg_stop;
    logic          cfg_no_scramble;
    logic          cfg_num_pkts_en;
    logic [31:0]   cfg_seed;
    logic [LW-1:0] cfg_pkt_len;
    logic [CW-1:0] cfg_num_pkts;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          stat_busy;
    logic          stat_done;
    logic [CW-1:0] stat_pkt_cnt;

    int checks = 0;
    int errors = 0;

    c2h_stream_pkt_gen #(
        .DATA_WIDTH(DW), .USER_WIDTH(UW), .LEN_WIDTH(LW), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_start(cfg_start), .cfg_stop(cfg_stop),
        .cfg_no_scramble(cfg_no_scramble), .cfg_num_pkts_en(cfg_num_pkts_en),
        .cfg_seed(cfg_seed), .cfg_pkt_len(cfg_pkt_len), .cfg_num_pkts(cfg_num_pkts),
        .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
        .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
        .stat_busy(stat_busy), .stat_done(stat_done), .stat_pkt_cnt(stat_pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference beat: bit-by-bit rotation of D for each dword lane.
    function automatic logic [DW-1:0] exp_data(input logic [31:0] d, input logic noscr);
        logic [DW-1:0] r;
        logic [31:0]   w;
        r = '0;
        for (int j = 0; j < DW / 32; j++) begin
            w = d;
            if (!noscr) begin
                for (int k = 0; k < (j % 32); k++) w = {w[30:0], w[31]};
            end
            r[32*j +: 32] = w;
        end
        return r;
    endfunction

    task automatic start_run(input logic [31:0] seed, input logic [LW-1:0] len,
                             input logic [CW-1:0] num, input logic noscr, input logic numen);
        @(negedge clk);
        cfg_seed        = seed;
        cfg_pkt_len     = len;
        cfg_num_pkts    = num;
        cfg_no_scramble = noscr;
        cfg_num_pkts_en = numen;
        cfg_start       = 1'b1;
        @(negedge clk);
        cfg_start       = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL reset_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tkeep !== {KW{1'b1}}) begin errors++; $display("[TB] FAIL reset_tkeep: got %h expected all ones", m_axis_tkeep); end
        checks++; if (m_axis_tdata !== '0) begin errors++; $display("[TB] FAIL reset_tdata: got %h expected 0", m_axis_tdata); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("[TB] FAIL reset_tlast: got %b expected 0", m_axis_tlast); end
        checks++; if (m_axis_tuser !== '0) begin errors++; $display("[TB] FAIL reset_tuser: got %h expected 0", m_axis_tuser); end
        checks++; if (stat_busy !== 1'b0) begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", stat_busy); end
        checks++; if (stat_done !== 1'b0) begin errors++; $display("[TB] FAIL reset_done: got %b expected 0", stat_done); end
        checks++; if (stat_pkt_cnt !== '0) begin errors++; $display("[TB] FAIL reset_pkt_cnt: got %0d expected 0", stat_pkt_cnt); end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single_beat;
        m_axis_tready = 1'b1;
        start_run(32'haaaa_0000, 16'd1, 32'd1, 1'b1, 1'b1);
        for (int i = 0; i < 2; i++) begin
            checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL single_tvalid[%0d]: got %b expected 1", i, m_axis_tvalid); end
            checks++; if (m_axis_tdata !== exp_data(32'haaaa_0000 + i, 1'b1)) begin errors++; $display("[TB] FAIL single_tdata[%0d]: got %h expected %h", i, m_axis_tdata, exp_data(32'haaaa_0000 + i, 1'b1)); end
            checks++; if (m_axis_tlast !== 1'b1) begin errors++; $display("[TB] FAIL single_tlast[%0d]: got %b expected 1", i, m_axis_tlast); end
            checks++; if (m_axis_tuser !== 64'(i)) begin errors++; $display("[TB] FAIL single_tuser[%0d]: got %0d expected %0d", i, m_axis_tuser, i); end
            checks++; if (stat_done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_early[%0d]: got %b expected 0", i, stat_done); end
            @(negedge clk);
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL single_end_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (stat_done !== 1'b1) begin errors++; $display("[TB] FAIL single_done: got %b expected 1", stat_done); end
        checks++; if (stat_pkt_cnt !== 32'd2) begin errors++; $display("[TB] FAIL single_pkt_cnt: got %0d expected 2", stat_pkt_cnt); end
        checks++; if (stat_busy !== 1'b0) begin errors++; $display("[TB] FAIL single_busy: got %b expected 0", stat_busy); end
        @(negedge clk);
        checks++; if (stat_done !== 1'b0) begin errors++; $display("[TB] FAIL single_done_pulse: got %b expected 0", stat_done); end
    endtask

    task automatic test_multi_beat;
        logic el;
        m_axis_tready = 1'b1;
        start_run(32'h0, 16'd4, 32'd2, 1'b1, 1'b1);
        for (int i = 0; i < 12; i++) begin
            el = ((i % 4) == 3);
            checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL multi_tvalid[%0d]: got %b expected 1", i, m_axis_tvalid); end
            checks++; if (m_axis_tdata !== exp_data(32'(i), 1'b1)) begin errors++; $display("[TB] FAIL multi_tdata[%0d]: got %h expected %h", i, m_axis_tdata, exp_data(32'(i), 1'b1)); end
            checks++; if (m_axis_tlast !== el) begin errors++; $display("[TB] FAIL multi_tlast[%0d]: got %b expected %b", i, m_axis_tlast, el); end
            checks++; if (m_axis_tuser !== 64'(i / 4)) begin errors++; $display("[TB] FAIL multi_tuser[%0d]: got %0d expected %0d", i, m_axis_tuser, i / 4); end
            @(negedge clk);
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL multi_end_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (stat_done !== 1'b1) begin errors++; $display("[TB] FAIL multi_done: got %b expected 1", stat_done); end
        checks++; if (stat_pkt_cnt !== 32'd3) begin errors++; $display("[TB] FAIL multi_pkt_cnt: got %0d expected 3", stat_pkt_cnt); end
    endtask

    task automatic test_backpressure;
        logic [7:0]  pat;
        logic [31:0] seed;
        int          n;
        int          k;
        pat  = 8'b1011_0010;
        seed = 32'h1234_5678;
        n    = 0;
        k    = 0;
        m_axis_tready = 1'b0;
        start_run(seed, 16'd3, 32'd0, 1'b0, 1'b1);
        while (n < 3 && k < 8) begin
            m_axis_tready = pat[k];
            checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL bp_tvalid[%0d]: got %b expected 1", k, m_axis_tvalid); end
            checks++; if (m_axis_tdata !== exp_data(seed + 32'(n), 1'b0)) begin errors++; $display("[TB] FAIL bp_tdata[%0d]: got %h expected %h", k, m_axis_tdata, exp_data(seed + 32'(n), 1'b0)); end
            checks++; if (m_axis_tlast !== (n == 2)) begin errors++; $display("[TB] FAIL bp_tlast[%0d]: got %b expected %b", k, m_axis_tlast, (n == 2)); end
            checks++; if (m_axis_tuser !== '0) begin errors++; $display("[TB] FAIL bp_tuser[%0d]: got %0d expected 0", k, m_axis_tuser); end
            if (pat[k]) n++;
            k++;
            @(negedge clk);
        end
        m_axis_tready = 1'b1;
        checks++; if (n != 3) begin errors++; $display("[TB] FAIL bp_transfers: got %0d expected 3", n); end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL bp_end_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (stat_done !== 1'b1) begin errors++; $display("[TB] FAIL bp_done: got %b expected 1", stat_done); end
        checks++; if (stat_pkt_cnt !== 32'd1) begin errors++; $display("[TB] FAIL bp_pkt_cnt: got %0d expected 1", stat_pkt_cnt); end
    endtask

    task automatic test_scramble;
        m_axis_tready = 1'b1;
        start_run(32'h1, 16'd1, 32'd1, 1'b0, 1'b1);
        for (int j = 0; j < DW / 32; j++) begin
            checks++; if (m_axis_tdata[32*j +: 32] !== (32'h1 << j)) begin errors++; $display("[TB] FAIL scr_beat0_dw[%0d]: got %h expected %h", j, m_axis_tdata[32*j +: 32], 32'h1 << j); end
        end
        @(negedge clk);
        for (int j = 0; j < DW / 32; j++) begin
            checks++; if (m_axis_tdata[32*j +: 32] !== (32'h2 << j)) begin errors++; $display("[TB] FAIL scr_beat1_dw[%0d]: got %h expected %h", j, m_axis_tdata[32*j +: 32], 32'h2 << j); end
        end
        @(negedge clk);
        checks++; if (stat_done !== 1'b1) begin errors++; $display("[TB] FAIL scr_done: got %b expected 1", stat_done); end
    endtask

    task automatic test_len_zero;
        m_axis_tready = 1'b1;
        start_run(32'h10, 16'd0, 32'd2, 1'b1, 1'b1);
        for (int i = 0; i < 3; i++) begin
            checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL len0_tvalid[%0d]: got %b expected 1", i, m_axis_tvalid); end
            checks++; if (m_axis_tdata !== exp_data(32'h10 + i, 1'b1)) begin errors++; $display("[TB] FAIL len0_tdata[%0d]: got %h expected %h", i, m_axis_tdata, exp_data(32'h10 + i, 1'b1)); end
            checks++; if (m_axis_tlast !== 1'b1) begin errors++; $display("[TB] FAIL len0_tlast[%0d]: got %b expected 1", i, m_axis_tlast); end
            checks++; if (m_axis_tuser !== 64'(i)) begin errors++; $display("[TB] FAIL len0_tuser[%0d]: got %0d expected %0d", i, m_axis_tuser, i); end
            @(negedge clk);
        end
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL len0_end_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (stat_pkt_cnt !== 32'd3) begin errors++; $display("[TB] FAIL len0_pkt_cnt: got %0d expected 3", stat_pkt_cnt); end
    endtask

    task automatic test_continuous_stop;
        logic el;
        m_axis_tready = 1'b1;
        start_run(32'h100, 16'd8, 32'd0, 1'b1, 1'b0);
        // A second start with a different seed mid-run must be ignored; stop lands on packet 5 beat 3.
        for (int n = 0; n < 48; n++) begin
            cfg_start = (n == 10);
            cfg_seed  = (n == 10) ? 32'hdead_beef : 32'h100;
            cfg_stop  = (n == 43);
            el = ((n % 8) == 7);
            checks++; if (m_axis_tvalid !== 1'b1) begin errors++; $display("[TB] FAIL cont_tvalid[%0d]: got %b expected 1", n, m_axis_tvalid); end
            checks++; if (m_axis_tdata !== exp_data(32'h100 + n, 1'b1)) begin errors++; $display("[TB] FAIL cont_tdata[%0d]: got %h expected %h", n, m_axis_tdata, exp_data(32'h100 + n, 1'b1)); end
            checks++; if (m_axis_tlast !== el) begin errors++; $display("[TB] FAIL cont_tlast[%0d]: got %b expected %b", n, m_axis_tlast, el); end
            checks++; if (m_axis_tuser !== 64'(n / 8)) begin errors++; $display("[TB] FAIL cont_tuser[%0d]: got %0d expected %0d", n, m_axis_tuser, n / 8); end
            checks++; if (stat_busy !== 1'b1) begin errors++; $display("[TB] FAIL cont_busy[%0d]: got %b expected 1", n, stat_busy); end
            @(negedge clk);
        end
        cfg_start = 1'b0;
        cfg_stop  = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL cont_end_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (stat_done !== 1'b1) begin errors++; $display("[TB] FAIL cont_done: got %b expected 1", stat_done); end
        checks++; if (stat_pkt_cnt !== 32'd6) begin errors++; $display("[TB] FAIL cont_pkt_cnt: got %0d expected 6", stat_pkt_cnt); end
        checks++; if (stat_busy !== 1'b0) begin errors++; $display("[TB] FAIL cont_end_busy: got %b expected 0", stat_busy); end
    endtask

    task automatic test_reset_restart;
        m_axis_tready = 1'b1;
        start_run(32'h50, 16'd8, 32'd0, 1'b1, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_tlast: got %b expected 0", m_axis_tlast); end
        checks++; if (stat_busy !== 1'b0) begin errors++; $display("[TB] FAIL rst_mid_busy: got %b expected 0", stat_busy); end
        @(negedge clk);
        rst_n = 1'b1;
        // Restart in continuous mode and stop exactly on the first tlast beat.
        start_run(32'h7777_0000, 16'd2, 32'd0, 1'b1, 1'b0);
        checks++; if (m_axis_tdata !== exp_data(32'h7777_0000, 1'b1)) begin errors++; $display("[TB] FAIL restart_tdata0: got %h expected %h", m_axis_tdata, exp_data(32'h7777_0000, 1'b1)); end
        checks++; if (m_axis_tlast !== 1'b0) begin errors++; $display("[TB] FAIL restart_tlast0: got %b expected 0", m_axis_tlast); end
        @(negedge clk);
        checks++; if (m_axis_tdata !== exp_data(32'h7777_0001, 1'b1)) begin errors++; $display("[TB] FAIL restart_tdata1: got %h expected %h", m_axis_tdata, exp_data(32'h7777_0001, 1'b1)); end
        checks++; if (m_axis_tlast !== 1'b1) begin errors++; $display("[TB] FAIL restart_tlast1: got %b expected 1", m_axis_tlast); end
        cfg_stop = 1'b1;
        @(negedge clk);
        cfg_stop = 1'b0;
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL stoplast_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (stat_done !== 1'b1) begin errors++; $display("[TB] FAIL stoplast_done: got %b expected 1", stat_done); end
        checks++; if (stat_pkt_cnt !== 32'd1) begin errors++; $display("[TB] FAIL stoplast_pkt_cnt: got %0d expected 1", stat_pkt_cnt); end
        @(negedge clk);
        checks++; if (m_axis_tvalid !== 1'b0) begin errors++; $display("[TB] FAIL stoplast_idle_tvalid: got %b expected 0", m_axis_tvalid); end
        checks++; if (stat_done !== 1'b0) begin errors++; $display("[TB] FAIL stoplast_done_pulse: got %b expected 0", stat_done); end
    endtask

    initial begin
        rst_n           = 1'b0;
        cfg_start       = 1'b0;
        cfg_stop        = 1'b0;
        cfg_no_scramble = 1'b0;
        cfg_num_pkts_en = 1'b0;
        cfg_seed        = '0;
        cfg_pkt_len     = '0;
        cfg_num_pkts    = '0;
        m_axis_tready   = 1'b0;
        $display("[TB] starting c2h_stream_pkt_gen bench");
        test_reset();
        test_single_beat();
        test_multi_beat();
        test_backpressure();
        test_scramble();
        test_len_zero();
        test_continuous_stop();
        test_reset_restart();
        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
